// File: rtl/lsu_req_pkg.sv
// Shared definitions for the load/store request stage: bus widths, RV32I
// load/store funct3 codes, FSM state encoding and funct3 legality helpers.
package lsu_req_pkg;

  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int CacheDataBus = 32;

  localparam logic [RegBus-1:0]     ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] ZeroReg  = '0;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2
  } lsu_state_e;

  // Loads exist for byte/half/word plus the two unsigned variants.
  function automatic logic load_f3_ok(input logic [2:0] f3);
    case (f3)
      INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU: load_f3_ok = 1'b1;
      default:                                       load_f3_ok = 1'b0;
    endcase
  endfunction

  // Stores exist only for byte/half/word.
  function automatic logic store_f3_ok(input logic [2:0] f3);
    case (f3)
      INST_SB, INST_SH, INST_SW: store_f3_ok = 1'b1;
      default:                   store_f3_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: turns funct3, the low address bits and the store source
// into cache byte enables, lane-replicated write data and a misaligned flag.
module lsu_align
  import lsu_req_pkg::*;
(
  input  logic [2:0]              funct3,
  input  logic                    is_load,
  input  logic [1:0]              addr_lo,
  input  logic [RegBus-1:0]       rs2,
  output logic [3:0]              byteenable,
  output logic [CacheDataBus-1:0] writedata,
  output logic                    misaligned
);

  // Loads always fetch the whole word; stores enable only the touched lanes.
  always_comb begin
    byteenable = 4'b1111;
    writedata  = rs2;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: begin
        if (!is_load) byteenable = 4'b0001 << addr_lo;
        writedata = {4{rs2[7:0]}};
      end
      3'b001, 3'b101: begin
        if (!is_load) byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{rs2[15:0]}};
        misaligned = addr_lo[0];
      end
      3'b010: begin
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_req.sv
// Load/store request stage. Takes one memory op from execute, registers the
// word address, enables and store data, and drives the cache port until the
// cache accepts (i_p_waitrequest low). Loads then wait for read data.
//
// Handshake: execute's op is taken on a rising edge where ex_valid and
// lsu_ready are both high; the cache command is taken on a rising edge where
// o_p_read or o_p_write is high and i_p_waitrequest is low; all command
// fields hold steady until then.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned H/W ops are
// consumed without issuing and reported on misalign_o / misalign_addr_o).
module lsu_req
  import lsu_req_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic                    ex_is_load,
  input  logic                    ex_is_store,
  input  logic [2:0]              ex_funct3,
  input  logic [RegBus-1:0]       ex_rs1_data,
  input  logic [RegBus-1:0]       ex_imm,
  input  logic [RegBus-1:0]       ex_rs2_data,
  input  logic [RegAddrBus-1:0]   ex_rd,
  output logic                    lsu_ready,
  output logic                    stall_o,
  output logic [RegBus-1:0]       o_p_addr,
  output logic                    o_p_read,
  output logic                    o_p_write,
  output logic [CacheDataBus-1:0] o_p_writedata,
  output logic [3:0]              o_p_byteenable,
  input  logic                    i_p_waitrequest,
  input  logic                    i_p_readdata_valid,
  output logic                    ex_read_mem,
  output logic [RegAddrBus-1:0]   reg_wait_wb,
  output logic [1:0]              mask_wait_wb,
  output logic [2:0]              ifunct3_wait_wb,
  output logic [1:0]              state_dbg
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic                    misalign_o,
  output logic [RegBus-1:0]       misalign_addr_o
`endif
);

  lsu_state_e state, state_next;

  logic [RegBus-1:0]       addr_q;
  logic [2:0]              funct3_q;
  logic [RegAddrBus-1:0]   rd_q;
  logic [CacheDataBus-1:0] wdata_q;
  logic [3:0]              be_q;
  logic                    is_load_q;

  logic [RegBus-1:0]       eff_addr;
  logic [3:0]              align_be;
  logic [CacheDataBus-1:0] align_wdata;
  logic                    misaligned;
  logic                    accept;
  logic                    op_load;
  logic                    op_defined;
  logic                    issue;

  assign eff_addr = ex_rs1_data + ex_imm;
  assign accept   = ex_valid & lsu_ready;
  assign op_load  = ex_is_load;

  // Load wins when both type bits are set; undefined funct3 is simply dropped.
  assign op_defined = ex_is_load  ? load_f3_ok(ex_funct3)
                    : ex_is_store ? store_f3_ok(ex_funct3)
                    : 1'b0;

  lsu_align u_align (
    .funct3     (ex_funct3),
    .is_load    (op_load),
    .addr_lo    (eff_addr[1:0]),
    .rs2        (ex_rs2_data),
    .byteenable (align_be),
    .writedata  (align_wdata),
    .misaligned (misaligned)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  assign issue = accept & op_defined & ~misaligned;

  // One-cycle report of a swallowed misaligned op and its effective address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= ZeroWord;
    end else begin
      misalign_o <= accept & op_defined & misaligned;
      if (accept & op_defined & misaligned) misalign_addr_o <= eff_addr;
    end
  end
`else
  // Without the check the low address bits only steer lanes.
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign issue = accept & op_defined;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state and command outputs.
  always_comb begin
    state_next  = state;
    lsu_ready   = 1'b0;
    o_p_read    = 1'b0;
    o_p_write   = 1'b0;
    ex_read_mem = 1'b0;
    case (state)
      ST_IDLE: begin
        lsu_ready = rst;
        if (issue) state_next = ST_REQ;
      end
      ST_REQ: begin
        o_p_read    = is_load_q;
        o_p_write   = ~is_load_q;
        ex_read_mem = is_load_q & ~i_p_waitrequest;
        if (!i_p_waitrequest) state_next = is_load_q ? ST_WAIT_RD : ST_IDLE;
      end
      ST_WAIT_RD: begin
        if (i_p_readdata_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the op on issue; fields then hold through the load's return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= ZeroWord;
      funct3_q  <= 3'b000;
      rd_q      <= ZeroReg;
      wdata_q   <= '0;
      be_q      <= 4'b0000;
      is_load_q <= 1'b0;
    end else if (issue) begin
      addr_q    <= eff_addr;
      funct3_q  <= ex_funct3;
      rd_q      <= ex_rd;
      wdata_q   <= align_wdata;
      be_q      <= align_be;
      is_load_q <= op_load;
    end
  end

  assign stall_o         = ex_valid & (ex_is_load | ex_is_store) & ~lsu_ready;
  assign o_p_addr        = {addr_q[RegBus-1:2], 2'b00};
  assign o_p_writedata   = wdata_q;
  assign o_p_byteenable  = be_q;
  assign reg_wait_wb     = rd_q;
  assign mask_wait_wb    = addr_q[1:0];
  assign ifunct3_wait_wb = funct3_q;
  assign state_dbg       = state;

endmodule
